// File: rtl/pipe_hazard_ctrl.sv
// ID/EX hazard scheduler: load-use stalls, branch bubbles, CP0 flush FSM and mult/div busy window.
// Optional performance counters are enabled by defining HAZ_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_ra,
  input  logic [4:0] id_rb,
  input  logic       id_use_rb,
  input  logic       id_md_start,
  input  logic       id_md_use,
  input  logic [4:0] ex_rw,
  input  logic       ex_regWr,
  input  logic [1:0] ex_memtoreg,
  input  logic       ex_branch_taken,
  input  logic       exc_req,
  input  logic       eret_req,
  output logic       hazard,
  output logic       BranchBubble,
  output logic [1:0] cp0bubble,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
`ifdef HAZ_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] md_wait_cnt,
`endif
  output logic       md_busy
);

  typedef enum logic [1:0] {IDLE, EXC1, EXC2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic load_use;
  logic md_busy_w;
  logic md_wait;
  logic exc_evt;
  logic md_wait_stall;

  assign load_use  = ex_regWr && (ex_memtoreg == 2'd1) && (ex_rw != 5'd0) &&
                     ((ex_rw == id_ra) || (id_use_rb && (ex_rw == id_rb)));
  assign md_busy_w = (md_cnt_q != '0);
  assign md_wait   = md_busy_w && (id_md_use || id_md_start);
  assign exc_evt   = exc_req || eret_req;

  always_comb begin
    state_d       = state_q;
    md_cnt_d      = md_busy_w ? (md_cnt_q - 1'b1) : md_cnt_q;
    hazard        = 1'b0;
    BranchBubble  = 1'b0;
    cp0bubble     = 2'd0;
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    ifid_flush    = 1'b0;
    md_wait_stall = 1'b0;

    case (state_q)
      IDLE:    if (exc_evt) state_d = EXC1;
      EXC1:    state_d = EXC2;
      EXC2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Priority chain: CP0 flush > taken branch > load-use > mult/div wait.
    // A flushed ID instruction never starts a mult/div, so the counter only loads in the last branch.
    if (state_q == EXC1) begin
      BranchBubble = 1'b1;
      ifid_flush   = 1'b1;
      cp0bubble    = 2'd1;
    end else if (state_q == EXC2) begin
      BranchBubble = 1'b1;
      cp0bubble    = 2'd2;
    end else if (exc_evt) begin
      // Flush begins next edge; suppress everything lower this cycle.
    end else if (ex_branch_taken) begin
      BranchBubble = 1'b1;
      ifid_flush   = 1'b1;
    end else if (load_use) begin
      hazard     = 1'b1;
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else if (md_wait) begin
      hazard        = 1'b1;
      pc_stall      = 1'b1;
      ifid_stall    = 1'b1;
      md_wait_stall = 1'b1;
    end else if (id_md_start) begin
      md_cnt_d = CNT_W'(MD_CYCLES - 1);
    end

    if (rst) begin
      hazard        = 1'b0;
      BranchBubble  = 1'b0;
      cp0bubble     = 2'd0;
      pc_stall      = 1'b0;
      ifid_stall    = 1'b0;
      ifid_flush    = 1'b0;
      md_wait_stall = 1'b0;
    end
  end

  assign md_busy = md_busy_w && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] md_wait_cnt_q, md_wait_cnt_d;

  always_comb begin
    stall_cnt_d   = stall_cnt_q   + {31'd0, pc_stall};
    flush_cnt_d   = flush_cnt_q   + {31'd0, BranchBubble};
    md_wait_cnt_d = md_wait_cnt_q + {31'd0, md_wait_stall};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      md_wait_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      md_wait_cnt_q <= md_wait_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign md_wait_cnt = md_wait_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control scheduler for the ID/EX register stage.
- Generates the `hazard`, `BranchBubble` and `cp0bubble` controls consumed by the ID/EX register, plus stall enables for PC and IF/ID.
- Sequences load-use stalls, taken-branch bubbles, CP0 exception/ERET flush, and the multi-cycle HI/LO multiply/divide busy window.
- Sits beside the decoder; purely control, no datapath storage.

Parameters:
- MD_CYCLES, 32, cycles a mult/div occupies the HI/LO unit (legal range 2..63).
- CNT_W, 6, width of the mult/div busy counter.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- id_ra  in  5  rs of instruction in ID.
- id_rb  in  5  rt of instruction in ID.
- id_use_rb  in  1  ID instruction reads rt.
- id_md_start  in  1  ID instruction is mult/multu/div/divu.
- id_md_use  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- ex_rw  in  5  destination register in EX.
- ex_regWr  in  1  EX writes the register file.
- ex_memtoreg  in  2  EX writeback select; 2'd1 = load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- exc_req  in  1  CP0 exception/interrupt request.
- eret_req  in  1  ERET in EX.
- hazard  out  1  bubble ID/EX (load-use or md wait).
- BranchBubble  out  1  bubble ID/EX on redirect.
- cp0bubble  out  2  CP0 op suppress code for ID/EX.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  clear IF/ID.
- md_busy  out  1  HI/LO unit occupied.

Behaviour:
- Reset values (async, immediate): state=IDLE, md counter=0, all outputs 0.
- load_use = ex_regWr & (ex_memtoreg==2'd1) & (ex_rw!=0) & ((ex_rw==id_ra) | (id_use_rb & ex_rw==id_rb)). Combinational; asserts hazard, pc_stall and ifid_stall in the same cycle. Exactly one bubble, because the load leaves EX on the next edge.
- Mult/div counter:
  - id_md_start accepted while not busy and not stalled → counter loads MD_CYCLES-1 at the next edge; md_busy=1 while counter≠0.
  - Counter decrements each edge and saturates at 0.
  - If id_md_use or id_md_start is in ID while md_busy → hazard=pc_stall=ifid_stall=1 until md_busy falls; the instruction issues in the first cycle with md_busy=0.
- FSM states:
  - IDLE: normal operation.
  - EXC1: entered at the next edge after exc_req or eret_req is seen in IDLE. Outputs BranchBubble=1, ifid_flush=1, cp0bubble=2'd1. Always advances to EXC2.
  - EXC2: BranchBubble=1, cp0bubble=2'd2. Returns to IDLE.
  - Total flush window is 2 cycles. exc_req arriving during EXC1/EXC2 is ignored.
- Taken branch in IDLE: BranchBubble=1 and ifid_flush=1 for that cycle only (combinational, 1-cycle bubble). No state change.
- Priority, highest first:
  1. rst
  2. exc_req/eret_req, or FSM in EXC1/EXC2
  3. ex_branch_taken
  4. load_use
  5. mult/div wait
- When a flush is active, hazard=0 and both stalls are 0: the flush wins and the stall is dropped.
- Mid-operation rst: counter and FSM clear immediately, md_busy drops asynchronously.
- Branch taken and load_use in the same cycle: BranchBubble=1, hazard=0, no stall.

Optional Feature:
- Macro: HAZ_PERF_EN.
- When defined, adds three output ports, each 32 bits, wrapping at 2^32, cleared by rst:
  - stall_cnt: increments each cycle pc_stall=1.
  - flush_cnt: increments each cycle BranchBubble=1.
  - md_wait_cnt: increments each cycle the stall is caused by mult/div wait.
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-busy (counter=10) → md_busy=0, all outputs 0 within the same cycle; state IDLE after release.
- Load-use: ex_memtoreg=1, ex_regWr=1, ex_rw=5, id_ra=5 → hazard=pc_stall=ifid_stall=1 for exactly 1 cycle. Repeat with ex_rw=0 → no stall.
- Mult then mflo: id_md_start in cycle 0, id_md_use in cycle 1, MD_CYCLES=32 → stall cycles 1..31; mflo issues in cycle 32.
- Branch plus load-use: ex_branch_taken=1 with a matching load_use → BranchBubble=1, ifid_flush=1, hazard=0 for 1 cycle.
- Exception: exc_req pulse in cycle 0 → cycle 1 cp0bubble=1 and BranchBubble=1; cycle 2 cp0bubble=2 and BranchBubble=1; cycle 3 all 0. A second exc_req in cycle 1 is ignored.
- HAZ_PERF_EN: run the load-use, branch and mult scenarios back to back → stall_cnt=32, flush_cnt=1, md_wait_cnt=31.
